// File: rtl/ps2_mouse_rx_pkg.sv
// Shared definitions for the PS/2 mouse receiver: frame FSM encoding,
// byte0 header bit positions, default screen size and axis arithmetic.
package ps2_mouse_rx_pkg;

    // Device-to-host frame deframer states
    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_e;

    // Bit positions inside the first byte of a standard 3-byte packet
    localparam int B0_LEFT    = 0;
    localparam int B0_RIGHT   = 1;
    localparam int B0_ALWAYS1 = 3;
    localparam int B0_XSIGN   = 4;
    localparam int B0_YSIGN   = 5;
    localparam int B0_XOVF    = 6;
    localparam int B0_YOVF    = 7;

    // Screen size also used by the object and display logic
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // 9-bit two's complement movement widened to 12 bits; overflow zeroes it
    function automatic logic signed [11:0] axis_delta(input logic sign,
                                                      input logic [7:0] mag,
                                                      input logic ovf);
        logic signed [11:0] r;
        if (ovf)
            r = 12'sd0;
        else
            r = {{3{sign}}, sign, mag};
        return r;
    endfunction

    // Saturate a signed candidate coordinate to 0..max_v (never wraps)
    function automatic logic [9:0] clamp_axis(input logic signed [11:0] v,
                                              input logic [9:0] max_v);
        logic [9:0] r;
        if (v < 12'sd0)
            r = 10'd0;
        else if (v > $signed({2'b00, max_v}))
            r = max_v;
        else
            r = v[9:0];
        return r;
    endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// Pin-side and cursor-side signals of the PS/2 mouse receiver.
// slave = the receiver, master = whatever drives the pins and uses the cursor.
interface ps2_mouse_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [9:0] mousex;
    logic [9:0] mousey;
    logic       mousepush;
    logic       mouseright;
    logic       pkt_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  mousex, mousey, mousepush, mouseright, pkt_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output mousex, mousey, mousepush, mouseright, pkt_valid, frame_err
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deframer: pin synchronizers, ps2_clk glitch filter,
// 11-bit frame FSM with odd-parity/stop check and inter-bit timeout.
module ps2_frame_rx
    import ps2_mouse_rx_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int BIT_TIMEOUT = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(BIT_TIMEOUT + 2);

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [FCW-1:0] filt_cnt_q;
    logic           filt_q, filt_prev_q;
    logic           strobe;

    frame_state_e   state_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           par_q;
    logic [TCW-1:0] tmo_q;
    logic [7:0]     byte_q;
    logic           byte_valid_q, frame_err_q;

    // Two-flop synchronizers; idle bus level is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_i;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt_q  <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            filt_prev_q <= filt_q;
            if (clk_s2_q == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_q     <= clk_s2_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // One-cycle sample strobe on each falling edge of the filtered clock
    assign strobe = filt_prev_q & ~filt_q;

    // Frame FSM: start, 8 data bits LSB first, parity, stop; bit timeout aborts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FR_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (strobe || state_q == FR_IDLE)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + 1'b1;

            if (strobe) begin
                case (state_q)
                    FR_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= FR_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    FR_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7)
                            state_q <= FR_PARITY;
                    end
                    FR_PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= FR_STOP;
                    end
                    FR_STOP: begin
                        if (dat_s2_q && (^{shift_q, par_q})) begin
                            byte_q       <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= FR_IDLE;
                    end
                    default: state_q <= FR_IDLE;
                endcase
            end else if (state_q != FR_IDLE && tmo_q > TCW'(BIT_TIMEOUT)) begin
                frame_err_q <= 1'b1;
                state_q     <= FR_IDLE;
            end
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver top: assembles 3-byte standard packets from the
// deframer and accumulates a clamped cursor position plus button state.
module ps2_mouse_rx
    import ps2_mouse_rx_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int INIT_X      = 320,
    parameter int INIT_Y      = 240,
    parameter int FILTER_LEN  = 8,
    parameter int BIT_TIMEOUT = 20000,
    parameter int PKT_TIMEOUT = 200000
) (
    input logic           clk,
    input logic           rst,
    ps2_mouse_rx_if.slave bus
);

    localparam int         PCW   = $clog2(PKT_TIMEOUT + 2);
    localparam logic [9:0] X_MAX = 10'(SCREEN_W - 1);
    localparam logic [9:0] Y_MAX = 10'(SCREEN_H - 1);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;

    logic [1:0]     idx_q;
    logic           hdr_left_q, hdr_right_q;
    logic           hdr_xsign_q, hdr_ysign_q, hdr_xovf_q, hdr_yovf_q;
    logic [7:0]     dx_lo_q;
    logic [PCW-1:0] pkt_tmo_q;

    logic [9:0] mousex_q, mousey_q;
    logic       push_q, right_q, pkt_valid_q;

    logic signed [11:0] dx, dy, nx, ny;
    logic [9:0]         mousex_d, mousey_d;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .BIT_TIMEOUT (BIT_TIMEOUT)
    ) u_frame (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk_i    (bus.ps2_clk),
        .ps2_data_i   (bus.ps2_data),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_err)
    );

    // Candidate position from the stored header/dx and the incoming dy byte;
    // PS/2 +y is up while screen rows grow downward, hence the subtraction
    always_comb begin
        dx       = axis_delta(hdr_xsign_q, dx_lo_q, hdr_xovf_q);
        dy       = axis_delta(hdr_ysign_q, rx_byte, hdr_yovf_q);
        nx       = $signed({2'b00, mousex_q}) + dx;
        ny       = $signed({2'b00, mousey_q}) - dy;
        mousex_d = clamp_axis(nx, X_MAX);
        mousey_d = clamp_axis(ny, Y_MAX);
    end

    // Packet assembler with inter-byte timeout, and cursor/button update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= 2'd0;
            hdr_left_q  <= 1'b0;
            hdr_right_q <= 1'b0;
            hdr_xsign_q <= 1'b0;
            hdr_ysign_q <= 1'b0;
            hdr_xovf_q  <= 1'b0;
            hdr_yovf_q  <= 1'b0;
            dx_lo_q     <= '0;
            pkt_tmo_q   <= '0;
            mousex_q    <= 10'(INIT_X);
            mousey_q    <= 10'(INIT_Y);
            push_q      <= 1'b0;
            right_q     <= 1'b0;
            pkt_valid_q <= 1'b0;
        end else begin
            pkt_valid_q <= 1'b0;
            if (rx_err) begin
                idx_q     <= 2'd0;
                pkt_tmo_q <= '0;
            end else if (rx_valid) begin
                pkt_tmo_q <= '0;
                case (idx_q)
                    2'd0: begin
                        // Header must have its always-one bit; otherwise resync
                        if (rx_byte[B0_ALWAYS1]) begin
                            hdr_left_q  <= rx_byte[B0_LEFT];
                            hdr_right_q <= rx_byte[B0_RIGHT];
                            hdr_xsign_q <= rx_byte[B0_XSIGN];
                            hdr_ysign_q <= rx_byte[B0_YSIGN];
                            hdr_xovf_q  <= rx_byte[B0_XOVF];
                            hdr_yovf_q  <= rx_byte[B0_YOVF];
                            idx_q       <= 2'd1;
                        end
                    end
                    2'd1: begin
                        dx_lo_q <= rx_byte;
                        idx_q   <= 2'd2;
                    end
                    default: begin
                        mousex_q    <= mousex_d;
                        mousey_q    <= mousey_d;
                        push_q      <= hdr_left_q;
                        right_q     <= hdr_right_q;
                        pkt_valid_q <= 1'b1;
                        idx_q       <= 2'd0;
                    end
                endcase
            end else if (idx_q != 2'd0) begin
                if (pkt_tmo_q > PCW'(PKT_TIMEOUT)) begin
                    idx_q     <= 2'd0;
                    pkt_tmo_q <= '0;
                end else begin
                    pkt_tmo_q <= pkt_tmo_q + 1'b1;
                end
            end else begin
                pkt_tmo_q <= '0;
            end
        end
    end

    assign bus.mousex     = mousex_q;
    assign bus.mousey     = mousey_q;
    assign bus.mousepush  = push_q;
    assign bus.mouseright = right_q;
    assign bus.pkt_valid  = pkt_valid_q;
    assign bus.frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: drives PS/2 frames on the pins and checks
// the cursor outputs and pulse counts against hand-computed values.
module tb_ps2_mouse_rx;

    localparam int FILTER_LEN  = 8;
    localparam int BIT_TIMEOUT = 20000;
    localparam int HALF        = 20;
    localparam int GAP         = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ps2_mouse_rx_if bus();

    ps2_mouse_rx #(
        .SCREEN_W    (640),
        .SCREEN_H    (480),
        .INIT_X      (320),
        .INIT_Y      (240),
        .FILTER_LEN  (FILTER_LEN),
        .BIT_TIMEOUT (BIT_TIMEOUT),
        .PKT_TIMEOUT (200000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int fall_cyc = 0;
    int pv_cyc   = 0;
    int pv_count = 0;
    int fe_count = 0;
    int checks   = 0;
    int passed   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor
    always @(negedge clk) begin
        if (bus.pkt_valid === 1'b1) begin
            pv_count <= pv_count + 1;
            pv_cyc   <= cyc;
        end
        if (bus.frame_err === 1'b1)
            fe_count <= fe_count + 1;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        if (glitch) begin
            bus.ps2_clk = 1'b0;
            repeat (FILTER_LEN - 1) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        bus.ps2_clk = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic bad_par,
                              input logic bad_stop, input int glitch_bit);
        logic [10:0] f;
        f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++)
            send_bit(f[i], i == glitch_bit);
        bus.ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 11, 1'b0, 1'b0, -1);
        send_frame(b1, 11, 1'b0, 1'b0, -1);
        send_frame(b2, 11, 1'b0, 1'b0, -1);
        $display("packet %02h %02h %02h -> x=%0d y=%0d L=%0b R=%0b",
                 b0, b1, b2, bus.mousex, bus.mousey, bus.mousepush, bus.mouseright);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.mousex !== 10'd320) $display("FAIL reset_x got=%0d exp=320", bus.mousex); else passed++;
        checks++; if (bus.mousey !== 10'd240) $display("FAIL reset_y got=%0d exp=240", bus.mousey); else passed++;
        checks++; if (bus.mousepush !== 1'b0) $display("FAIL reset_push got=%0b exp=0", bus.mousepush); else passed++;
        checks++; if (bus.mouseright !== 1'b0) $display("FAIL reset_right got=%0b exp=0", bus.mouseright); else passed++;
        checks++; if (bus.pkt_valid !== 1'b0) $display("FAIL reset_pkt_valid got=%0b exp=0", bus.pkt_valid); else passed++;
        checks++; if (bus.frame_err !== 1'b0) $display("FAIL reset_frame_err got=%0b exp=0", bus.frame_err); else passed++;
        do_reset();
    endtask

    task automatic test_basic();
        int pv0;
        do_reset();
        pv0 = pv_count;
        send_packet(8'h09, 8'h0A, 8'h05);
        checks++; if (bus.mousex !== 10'd330) $display("FAIL basic_x got=%0d exp=330", bus.mousex); else passed++;
        checks++; if (bus.mousey !== 10'd235) $display("FAIL basic_y got=%0d exp=235", bus.mousey); else passed++;
        checks++; if (bus.mousepush !== 1'b1) $display("FAIL basic_push got=%0b exp=1", bus.mousepush); else passed++;
        checks++; if (bus.mouseright !== 1'b0) $display("FAIL basic_right got=%0b exp=0", bus.mouseright); else passed++;
        checks++; if (pv_count - pv0 !== 1) $display("FAIL basic_pulses got=%0d exp=1", pv_count - pv0); else passed++;
        checks++; if (pv_cyc - fall_cyc !== FILTER_LEN + 4)
            $display("FAIL basic_latency got=%0d exp=%0d", pv_cyc - fall_cyc, FILTER_LEN + 4); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int pv0;
        do_reset();
        send_packet(8'h09, 8'h0A, 8'h05);
        send_frame(8'h09, 5, 1'b0, 1'b0, -1);
        pv0 = pv_count;
        rst = 1'b1;
        #1;
        checks++; if (bus.mousex !== 10'd320) $display("FAIL midrst_x got=%0d exp=320", bus.mousex); else passed++;
        checks++; if (bus.mousey !== 10'd240) $display("FAIL midrst_y got=%0d exp=240", bus.mousey); else passed++;
        checks++; if (bus.mousepush !== 1'b0) $display("FAIL midrst_push got=%0b exp=0", bus.mousepush); else passed++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (pv_count - pv0 !== 0) $display("FAIL midrst_pulses got=%0d exp=0", pv_count - pv0); else passed++;
        send_packet(8'h09, 8'h0A, 8'h05);
        checks++; if (bus.mousex !== 10'd330) $display("FAIL midrst_next_x got=%0d exp=330", bus.mousex); else passed++;
        checks++; if (bus.mousey !== 10'd235) $display("FAIL midrst_next_y got=%0d exp=235", bus.mousey); else passed++;
    endtask

    task automatic test_clamp_low();
        do_reset();
        send_packet(8'h18, 8'h00, 8'h00);
        checks++; if (bus.mousex !== 10'd64) $display("FAIL clamp_x1 got=%0d exp=64", bus.mousex); else passed++;
        send_packet(8'h18, 8'h00, 8'h00);
        checks++; if (bus.mousex !== 10'd0) $display("FAIL clamp_x0 got=%0d exp=0", bus.mousex); else passed++;
        send_packet(8'h08, 8'h00, 8'h80);
        checks++; if (bus.mousey !== 10'd112) $display("FAIL clamp_y1 got=%0d exp=112", bus.mousey); else passed++;
        send_packet(8'h08, 8'h00, 8'h80);
        checks++; if (bus.mousey !== 10'd0) $display("FAIL clamp_y0 got=%0d exp=0", bus.mousey); else passed++;
        checks++; if (bus.mousex !== 10'd0) $display("FAIL clamp_x_hold got=%0d exp=0", bus.mousex); else passed++;
    endtask

    task automatic test_clamp_high();
        do_reset();
        send_packet(8'h2A, 8'hFF, 8'h00);
        checks++; if (bus.mousex !== 10'd575) $display("FAIL high_x1 got=%0d exp=575", bus.mousex); else passed++;
        checks++; if (bus.mousey !== 10'd479) $display("FAIL high_y got=%0d exp=479", bus.mousey); else passed++;
        checks++; if (bus.mouseright !== 1'b1) $display("FAIL high_right got=%0b exp=1", bus.mouseright); else passed++;
        checks++; if (bus.mousepush !== 1'b0) $display("FAIL high_push got=%0b exp=0", bus.mousepush); else passed++;
        send_packet(8'h2A, 8'hFF, 8'h00);
        checks++; if (bus.mousex !== 10'd639) $display("FAIL high_x2 got=%0d exp=639", bus.mousex); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        send_packet(8'h48, 8'h10, 8'h10);
        checks++; if (bus.mousex !== 10'd320) $display("FAIL xovf_x got=%0d exp=320", bus.mousex); else passed++;
        checks++; if (bus.mousey !== 10'd224) $display("FAIL xovf_y got=%0d exp=224", bus.mousey); else passed++;
        send_packet(8'h88, 8'h10, 8'h10);
        checks++; if (bus.mousex !== 10'd336) $display("FAIL yovf_x got=%0d exp=336", bus.mousex); else passed++;
        checks++; if (bus.mousey !== 10'd224) $display("FAIL yovf_y got=%0d exp=224", bus.mousey); else passed++;
    endtask

    task automatic test_frame_errors();
        int pv0, fe0;
        do_reset();
        pv0 = pv_count;
        fe0 = fe_count;
        send_frame(8'h08, 11, 1'b0, 1'b0, -1);
        send_frame(8'h0A, 11, 1'b1, 1'b0, -1);
        checks++; if (fe_count - fe0 !== 1) $display("FAIL parity_err got=%0d exp=1", fe_count - fe0); else passed++;
        checks++; if (pv_count - pv0 !== 0) $display("FAIL parity_no_pkt got=%0d exp=0", pv_count - pv0); else passed++;
        send_frame(8'h08, 11, 1'b0, 1'b1, -1);
        checks++; if (fe_count - fe0 !== 2) $display("FAIL stop_err got=%0d exp=2", fe_count - fe0); else passed++;
        send_packet(8'h08, 8'h05, 8'h00);
        checks++; if (bus.mousex !== 10'd325) $display("FAIL err_next_x got=%0d exp=325", bus.mousex); else passed++;
        checks++; if (pv_count - pv0 !== 1) $display("FAIL err_next_pulses got=%0d exp=1", pv_count - pv0); else passed++;
    endtask

    task automatic test_discard();
        int pv0, fe0;
        do_reset();
        pv0 = pv_count;
        fe0 = fe_count;
        send_frame(8'h02, 11, 1'b0, 1'b0, -1);
        checks++; if (pv_count - pv0 !== 0) $display("FAIL discard_pkt got=%0d exp=0", pv_count - pv0); else passed++;
        checks++; if (fe_count - fe0 !== 0) $display("FAIL discard_err got=%0d exp=0", fe_count - fe0); else passed++;
        send_packet(8'h08, 8'h01, 8'h01);
        checks++; if (bus.mousex !== 10'd321) $display("FAIL discard_x got=%0d exp=321", bus.mousex); else passed++;
        checks++; if (bus.mousey !== 10'd239) $display("FAIL discard_y got=%0d exp=239", bus.mousey); else passed++;
    endtask

    task automatic test_glitch();
        int pv0, fe0;
        do_reset();
        pv0 = pv_count;
        fe0 = fe_count;
        send_frame(8'h08, 11, 1'b0, 1'b0, -1);
        send_frame(8'h0A, 11, 1'b0, 1'b0, 5);
        send_frame(8'h00, 11, 1'b0, 1'b0, -1);
        checks++; if (bus.mousex !== 10'd330) $display("FAIL glitch_x got=%0d exp=330", bus.mousex); else passed++;
        checks++; if (fe_count - fe0 !== 0) $display("FAIL glitch_err got=%0d exp=0", fe_count - fe0); else passed++;
        checks++; if (pv_count - pv0 !== 1) $display("FAIL glitch_pulses got=%0d exp=1", pv_count - pv0); else passed++;
    endtask

    task automatic test_timeout();
        int fe0;
        do_reset();
        fe0 = fe_count;
        send_frame(8'h08, 6, 1'b0, 1'b0, -1);
        repeat (BIT_TIMEOUT - 200) @(negedge clk);
        checks++; if (fe_count - fe0 !== 0) $display("FAIL timeout_early got=%0d exp=0", fe_count - fe0); else passed++;
        repeat (400) @(negedge clk);
        checks++; if (fe_count - fe0 !== 1) $display("FAIL timeout_err got=%0d exp=1", fe_count - fe0); else passed++;
        send_packet(8'h08, 8'h03, 8'h02);
        checks++; if (bus.mousex !== 10'd323) $display("FAIL timeout_next_x got=%0d exp=323", bus.mousex); else passed++;
        checks++; if (bus.mousey !== 10'd238) $display("FAIL timeout_next_y got=%0d exp=238", bus.mousey); else passed++;
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_reset_mid_frame();
        test_clamp_low();
        test_clamp_high();
        test_overflow();
        test_frame_errors();
        test_discard();
        test_glitch();
        test_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
